// File: rtl/mc_controller_if.sv
// Control bundle between the multicycle ARM-subset controller and its datapath.
// master = controller side (drives enables/selects), slave = datapath/IR side.
interface mc_controller_if #(
  parameter int ALUCTL_W = 2,
  parameter int CNT_W    = 16
);
  logic [3:0]          Cond;
  logic [1:0]          Op;
  logic [5:0]          Funct;
  logic [3:0]          Rd;
  logic [3:0]          ALUFlags;

  logic                PCWrite;
  logic                IRWrite;
  logic                MemW;
  logic                RegW;
  logic                AdrSrc;
  logic                LinkW;
  logic [1:0]          ResultSrc;
  logic [1:0]          ALUSrcA;
  logic [1:0]          ALUSrcB;
  logic [1:0]          ImmSrc;
  logic [1:0]          RegSrc;
  logic [ALUCTL_W-1:0] ALUControl;
  logic [3:0]          Flags;
  logic [CNT_W-1:0]    InstrCount;

  modport master (
    input  Cond, Op, Funct, Rd, ALUFlags,
    output PCWrite, IRWrite, MemW, RegW, AdrSrc, LinkW,
    output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc,
    output ALUControl, Flags, InstrCount
  );

  modport slave (
    output Cond, Op, Funct, Rd, ALUFlags,
    input  PCWrite, IRWrite, MemW, RegW, AdrSrc, LinkW,
    input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc,
    input  ALUControl, Flags, InstrCount
  );
endinterface

// File: rtl/mc_controller.sv
// Multicycle ARM-subset controller: Moore FSM, ALU decode, NZCV register, retired counter.
// Latency 2..5 cycles per instruction, no backpressure; MC_CTRL_BL_EN enables branch-with-link.
module mc_controller #(
  parameter int ALUCTL_W = 2,
  parameter int CNT_W    = 16
) (
  input  logic            clk,
  input  logic            reset,
  mc_controller_if.master bus
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BRANCH, UNDEF
  } state_t;

  localparam logic [ALUCTL_W-1:0] ALU_ADD = '0;
  localparam logic [ALUCTL_W-1:0] ALU_SUB = ALUCTL_W'(1);
  localparam logic [ALUCTL_W-1:0] ALU_AND = ALUCTL_W'(2);
  localparam logic [ALUCTL_W-1:0] ALU_ORR = ALUCTL_W'(3);
  localparam logic [ALUCTL_W-1:0] ALU_EOR = ALUCTL_W'(4);
  localparam logic [ALUCTL_W-1:0] ALU_MOV = ALUCTL_W'(5);

  state_t              state, state_nxt;
  logic [3:0]          flags;
  logic [CNT_W-1:0]    instr_cnt;

  logic                fn, fz, fc, fv;
  logic                cond_ok;
  logic [3:0]          cmd;
  logic                is_cmp, is_arith, pc_dest, in_exec;
  logic [ALUCTL_W-1:0] alu_dec;

  logic                pc_write, ir_write, mem_w, reg_w, adr_src, link_w;
  logic [1:0]          result_src, alu_src_a, alu_src_b;
  logic [ALUCTL_W-1:0] alu_ctl;

  assign {fn, fz, fc, fv} = flags;
  assign cmd      = bus.Funct[4:1];
  assign is_cmp   = (cmd == 4'b1010);
  assign is_arith = (cmd == 4'b0100) || (cmd == 4'b0010) || is_cmp;
  assign pc_dest  = (bus.Rd == 4'b1111);
  assign in_exec  = (state == EXECR) || (state == EXECI);

  // ARM condition codes against the registered flags; NV (1111) never executes.
  always_comb begin
    cond_ok = 1'b0;
    case (bus.Cond)
      4'b0000: cond_ok = fz;
      4'b0001: cond_ok = ~fz;
      4'b0010: cond_ok = fc;
      4'b0011: cond_ok = ~fc;
      4'b0100: cond_ok = fn;
      4'b0101: cond_ok = ~fn;
      4'b0110: cond_ok = fv;
      4'b0111: cond_ok = ~fv;
      4'b1000: cond_ok = fc & ~fz;
      4'b1001: cond_ok = ~fc | fz;
      4'b1010: cond_ok = (fn == fv);
      4'b1011: cond_ok = (fn != fv);
      4'b1100: cond_ok = ~fz & (fn == fv);
      4'b1101: cond_ok = fz | (fn != fv);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  always_comb begin
    alu_dec = ALU_ADD;
    case (cmd)
      4'b0100: alu_dec = ALU_ADD;
      4'b0010: alu_dec = ALU_SUB;
      4'b1010: alu_dec = ALU_SUB;
      4'b0000: alu_dec = ALU_AND;
      4'b1100: alu_dec = ALU_ORR;
      4'b0001: if (ALUCTL_W >= 3) alu_dec = ALU_EOR;
      4'b1101: if (ALUCTL_W >= 3) alu_dec = ALU_MOV;
      default: alu_dec = ALU_ADD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  // C and V only carry meaning for the adder ops; logic ops keep the old CV.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags <= 4'b0000;
    end else if (in_exec && bus.Funct[0]) begin
      flags[3:2] <= bus.ALUFlags[3:2];
      if (is_arith) flags[1:0] <= bus.ALUFlags[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                                   instr_cnt <= '0;
    else if (state != FETCH && state_nxt == FETCH) instr_cnt <= instr_cnt + CNT_W'(1);
  end

  always_comb begin
    state_nxt  = state;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_w      = 1'b0;
    reg_w      = 1'b0;
    adr_src    = 1'b0;
    link_w     = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_ctl    = ALU_ADD;
    case (state)
      FETCH: begin
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        state_nxt  = DECODE;
      end
      DECODE: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (!cond_ok) begin
          state_nxt = FETCH;
        end else begin
          case (bus.Op)
            2'b01:   state_nxt = MEMADR;
            2'b00:   state_nxt = bus.Funct[5] ? EXECI : EXECR;
            2'b10:   state_nxt = BRANCH;
            default: state_nxt = UNDEF;
          endcase
        end
      end
      MEMADR: begin
        alu_src_b = 2'b01;
        state_nxt = bus.Funct[0] ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adr_src   = 1'b1;
        state_nxt = MEMWB;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_w     = 1'b1;
        state_nxt = FETCH;
      end
      MEMWB: begin
        result_src = 2'b01;
        if (pc_dest) pc_write = 1'b1;
        else         reg_w    = 1'b1;
        state_nxt = FETCH;
      end
      EXECR: begin
        alu_src_b = 2'b00;
        alu_ctl   = alu_dec;
        state_nxt = ALUWB;
      end
      EXECI: begin
        alu_src_b = 2'b01;
        alu_ctl   = alu_dec;
        state_nxt = ALUWB;
      end
      ALUWB: begin
        // CMP only updates flags; a write to R15 redirects the PC instead.
        if (!is_cmp) begin
          if (pc_dest) pc_write = 1'b1;
          else         reg_w    = 1'b1;
        end
        state_nxt = FETCH;
      end
      BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = 1'b1;
`ifdef MC_CTRL_BL_EN
        if (bus.Funct[4] && cond_ok) begin
          reg_w      = 1'b1;
          link_w     = 1'b1;
          result_src = 2'b11;
        end
`endif
        state_nxt = FETCH;
      end
      UNDEF: begin
        state_nxt = FETCH;
      end
      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

  assign bus.PCWrite    = pc_write & ~reset;
  assign bus.IRWrite    = ir_write & ~reset;
  assign bus.MemW       = mem_w    & ~reset;
  assign bus.RegW       = reg_w    & ~reset;
  assign bus.LinkW      = link_w   & ~reset;
  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUControl = alu_ctl;
  assign bus.ImmSrc     = bus.Op;
  assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};
  assign bus.Flags      = flags;
  assign bus.InstrCount = instr_cnt;

endmodule

// File: doc/mc_controller.md
# mc_controller

Parametrised multicycle ARM-subset controller: Moore main FSM, ALU decoder with configurable control width, flag register with conditional-execution check, and retired-instruction counter. It sits between the instruction register and the multicycle datapath, driving every mux select and write enable. Compared with the previous decoder, this block owns the NZCV register and skips condition-failed instructions directly from DECODE. It also handles CMP/no-write, PC-destination writes, undefined ops and optional branch-with-link.

## Interface
- ALUCTL_W, 2, ALUControl width; 2 = ADD/SUB/AND/ORR, 3 adds EOR/MOV
- CNT_W, 16, width of retired-instruction counter
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- Cond  in  4  Instr[31:28]
- Op  in  2  Instr[27:26]
- Funct  in  6  Instr[25:20]
- Rd  in  4  Instr[15:12]
- ALUFlags  in  4  NZCV from ALU, current cycle
- PCWrite, IRWrite, MemW, RegW, AdrSrc, LinkW  out  1 each
- ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc  out  2 each
- ALUControl  out  ALUCTL_W
- Flags  out  4  registered NZCV
- InstrCount  out  CNT_W  retired (incl. skipped) instructions

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, UNDEF.
- Outputs per state; unlisted outputs are 0:
  - FETCH: IRWrite=1, PCWrite=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01.
  - MEMREAD: AdrSrc=1.
  - MEMWRITE: AdrSrc=1, MemW=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - EXECR: ALUSrcB=00.
  - EXECI: ALUSrcB=01.
  - ALUWB: RegW=1.
  - BRANCH: ALUSrcB=01, ResultSrc=10, PCWrite=1.
  - UNDEF: none.
- Transitions:
  - FETCH→DECODE.
  - DECODE→FETCH if the condition fails. Otherwise by Op: 01→MEMADR; 00 with Funct[5]=0→EXECR; 00 with Funct[5]=1→EXECI; 10→BRANCH; 11→UNDEF.
  - MEMADR→MEMREAD if Funct[0]=1, else MEMWRITE.
  - MEMREAD→MEMWB.
  - EXECR/EXECI→ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BRANCH, UNDEF→FETCH.
- Condition check uses the Flags register, with ARM semantics for all 15 codes. 1111 is treated as fail.
- PC destination: in MEMWB/ALUWB with Rd=1111, RegW=0 and PCWrite=1 (ResultSrc unchanged).
- ALU decode is active in EXECR/EXECI only; otherwise ALUControl=0 (ADD). Funct[4:1] mapping:
  - 0100 ADD→0, 0010 SUB→1, 1010 CMP→1, 0000 AND→2, 1100 ORR→3.
  - With ALUCTL_W=3: 0001 EOR→4, 1101 MOV→5.
  - Anything else→ADD.
- CMP: ALUWB asserts RegW=0 and PCWrite=0.
- Flags: written at the end of EXECR/EXECI when Funct[0]=1. NZ are always taken from ALUFlags; CV only for ADD/SUB/CMP.
- ImmSrc=Op. RegSrc[0]=(Op==10). RegSrc[1]=(Op==01).
- InstrCount: +1 on every transition into FETCH from any state other than FETCH. Wraps modulo 2^CNT_W.

## Timing
- Moore outputs: all outputs are a function of registered state plus current fields; no input-to-write-enable path except Rd/Funct decode.
- Instruction latency:
  - ADD/SUB/etc.: 4 cycles.
  - LDR: 5.
  - STR: 4.
  - B: 3.
  - Condition-failed or UNDEF: 2 or 3 respectively.
- Flags visible the cycle after EXECR/EXECI, i.e. in ALUWB, and therefore to the next DECODE.
- Reset:
  - While reset=1, PCWrite, IRWrite, MemW, RegW and LinkW are forced 0.
  - After the reset edge: state=FETCH, Flags=0000, InstrCount=0. Outputs then equal the FETCH encoding.
  - Reset mid-instruction abandons it; no pending write completes.
- ALUSrcA=00 / ALUSrcB=00 meaning register A / WriteData; other encodings as listed above.

## Configuration
- MC_CTRL_BL_EN defined: in BRANCH with Funct[4]=1 (L bit) and condition passed, assert RegW=1, LinkW=1 and ResultSrc=11 (datapath PC register = branch address+4 → R14).
- Undefined: LinkW tied 0; BL executes as plain B.

## Test plan
- Reset held 2 cycles, released → first state FETCH, IRWrite=1, PCWrite=1, Flags=0000, InstrCount=0.
- ADD with S=1 (Op=00, Funct=001001), ALUFlags=0110 → 4 cycles; ALUControl=0 in EXECR; Flags=0110 in ALUWB; RegW=1 in ALUWB; InstrCount=1.
- CMP (Funct=010101), ALUFlags=0100, then BEQ (Cond=0000) → CMP gives no RegW and Flags=0100; BEQ reaches BRANCH with PCWrite=1. Repeat with ALUFlags=0000 → BEQ returns to FETCH after DECODE and InstrCount still increments.
- LDR (Op=01, Funct[0]=1, Rd=1111) → sequence FETCH,DECODE,MEMADR,MEMREAD,MEMWB; RegW=0 and PCWrite=1 in MEMWB.
- ALUCTL_W=3, EOR (Funct[4:1]=0001) → ALUControl=100; ALUCTL_W=2 with the same instruction → ALUControl=00.
- MC_CTRL_BL_EN defined, BL (Op=10, Funct[4]=1), Cond=1110 → BRANCH with LinkW=1, RegW=1, ResultSrc=11; Op=11 → UNDEF for one cycle with no write enables, then FETCH.
